// File: rtl/alu_pipe.sv
// alu_pipe: two-stage elastic ALU pipeline with a valid/ready handshake on both sides.
// S1 holds the accepted operation, S2 holds the computed result and flags.
// Flags are {negative, zero, overflow, carry}. sticky_ovf accumulates overflow seen
// on output handshakes.
// Build option: define ALU_SAT_EN to enable saturating SADD (9) and SSUB (A).
// Without it, opcodes 9 and A behave like any other undefined opcode.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [SHW-1:0]   sh_amount,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    input  logic             clr_sticky,
    output logic             sticky_ovf
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_ROL  = 4'h5;
    localparam logic [3:0] OP_ROR  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
`ifdef ALU_SAT_EN
    localparam logic [3:0] OP_SADD = 4'h9;
    localparam logic [3:0] OP_SSUB = 4'hA;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // Stage 1: accepted operation
    logic             s1_valid_r;
    logic [3:0]       s1_opcode_r;
    logic [WIDTH-1:0] s1_op1_r;
    logic [WIDTH-1:0] s1_op2_r;
    logic [SHW-1:0]   s1_sh_r;

    // Stage 2: computed result
    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_result_r;
    logic [3:0]       s2_flags_r;
    logic             sticky_r;

    // Handshake and datapath intermediates
    logic             s1_adv_s;
    logic             in_ready_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic             add_ovf_s;
    logic             sub_ovf_s;
    logic [WIDTH-1:0] alu_result_s;
    logic             alu_ovf_s;
    logic             alu_carry_s;
    logic [3:0]       alu_flags_s;

    // S1 may move into S2 whenever S2 is empty or being drained this cycle.
    assign s1_adv_s   = !s2_valid_r || out_ready;
    // Holding off acceptance while rst is high keeps in_ready low during reset.
    assign in_ready_s = !rst && (!s1_valid_r || s1_adv_s);

    // Sign-extended (WIDTH+1)-bit add/subtract; bit WIDTH is reported as carry/borrow.
    assign add_s     = {s1_op1_r[WIDTH-1], s1_op1_r} + {s1_op2_r[WIDTH-1], s1_op2_r};
    assign sub_s     = {s1_op1_r[WIDTH-1], s1_op1_r} - {s1_op2_r[WIDTH-1], s1_op2_r};
    assign add_ovf_s = (s1_op1_r[WIDTH-1] == s1_op2_r[WIDTH-1]) && (add_s[WIDTH-1] != s1_op1_r[WIDTH-1]);
    assign sub_ovf_s = (s1_op1_r[WIDTH-1] != s1_op2_r[WIDTH-1]) && (sub_s[WIDTH-1] != s1_op1_r[WIDTH-1]);

    // Operation select for the operation held in S1.
    always_comb begin
        alu_result_s = {WIDTH{1'b0}};
        alu_ovf_s    = 1'b0;
        alu_carry_s  = 1'b0;
        case (s1_opcode_r)
            OP_ADD: begin
                alu_result_s = add_s[WIDTH-1:0];
                alu_ovf_s    = add_ovf_s;
                alu_carry_s  = add_s[WIDTH];
            end
            OP_SUB: begin
                alu_result_s = sub_s[WIDTH-1:0];
                alu_ovf_s    = sub_ovf_s;
                alu_carry_s  = sub_s[WIDTH];
            end
            OP_AND: alu_result_s = s1_op1_r & s1_op2_r;
            OP_OR:  alu_result_s = s1_op1_r | s1_op2_r;
            OP_XOR: alu_result_s = s1_op1_r ^ s1_op2_r;
            OP_ROL: begin
                if (s1_sh_r == {SHW{1'b0}}) begin
                    alu_result_s = s1_op1_r;
                end else begin
                    alu_result_s = (s1_op1_r << s1_sh_r) | (s1_op1_r >> (WIDTH - int'(s1_sh_r)));
                end
            end
            OP_ROR: begin
                if (s1_sh_r == {SHW{1'b0}}) begin
                    alu_result_s = s1_op1_r;
                end else begin
                    alu_result_s = (s1_op1_r >> s1_sh_r) | (s1_op1_r << (WIDTH - int'(s1_sh_r)));
                end
            end
            OP_SHL: alu_result_s = s1_op1_r << s1_sh_r;
            OP_SHR: alu_result_s = $signed(s1_op1_r) >>> s1_sh_r;
`ifdef ALU_SAT_EN
            // Overflow direction follows op1's sign: a positive op1 can only overflow upward.
            OP_SADD: begin
                alu_ovf_s = add_ovf_s;
                if (add_ovf_s) begin
                    alu_result_s = s1_op1_r[WIDTH-1] ? SAT_MIN : SAT_MAX;
                end else begin
                    alu_result_s = add_s[WIDTH-1:0];
                end
            end
            OP_SSUB: begin
                alu_ovf_s = sub_ovf_s;
                if (sub_ovf_s) begin
                    alu_result_s = s1_op1_r[WIDTH-1] ? SAT_MIN : SAT_MAX;
                end else begin
                    alu_result_s = sub_s[WIDTH-1:0];
                end
            end
`endif
            default: alu_result_s = {WIDTH{1'b0}};
        endcase
        alu_flags_s = {alu_result_s[WIDTH-1], (alu_result_s == {WIDTH{1'b0}}), alu_ovf_s, alu_carry_s};
    end

    // S1 capture: load a new operation whenever the input side is ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_opcode_r <= 4'h0;
            s1_op1_r    <= {WIDTH{1'b0}};
            s1_op2_r    <= {WIDTH{1'b0}};
            s1_sh_r     <= {SHW{1'b0}};
        end else if (in_ready_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_opcode_r <= opcode;
                s1_op1_r    <= op1;
                s1_op2_r    <= op2;
                s1_sh_r     <= sh_amount;
            end
        end
    end

    // S2 capture: register result and flags; hold them while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r  <= 1'b0;
            s2_result_r <= {WIDTH{1'b0}};
            s2_flags_r  <= 4'h0;
        end else if (s1_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_result_r <= alu_result_s;
                s2_flags_r  <= alu_flags_s;
            end
        end
    end

    // Sticky overflow: set on an overflowing output handshake, which beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_r <= 1'b0;
        end else if (s2_valid_r && out_ready && s2_flags_r[1]) begin
            sticky_r <= 1'b1;
        end else if (clr_sticky) begin
            sticky_r <= 1'b0;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = s2_valid_r;
    assign result     = s2_result_r;
    assign flags      = s2_flags_r;
    assign sticky_ovf = sticky_r;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table, multi-cycle corner sequences and a randomized
// scoreboard run against an arithmetic reference model. A 32-bit and a 16-bit
// instance share the clock and reset.
module tb_alu_pipe;

    logic clk = 1'b0;
    logic rst;

    // 32-bit instance
    logic        in_valid, in_ready, out_valid, out_ready, clr_sticky, sticky_ovf;
    logic [3:0]  opcode, flags;
    logic [31:0] op1, op2, result;
    logic [4:0]  sh_amount;

    // 16-bit instance
    logic        d16_in_valid, d16_in_ready, d16_out_valid, d16_out_ready, d16_clr, d16_sticky;
    logic [3:0]  d16_opcode, d16_flags;
    logic [15:0] d16_op1, d16_op2, d16_result;
    logic [3:0]  d16_sh;

    int checks   = 0;
    int failures = 0;
    logic sticky_exp;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp_res;
        logic [3:0]  exp_fl;
    } vec_t;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  fl;
    } exp_t;

    vec_t vt[15];
    exp_t sbq[$];

    alu_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .op1(op1), .op2(op2), .sh_amount(sh_amount),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags),
        .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf)
    );

    alu_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
        .opcode(d16_opcode), .op1(d16_op1), .op2(d16_op2), .sh_amount(d16_sh),
        .out_valid(d16_out_valid), .out_ready(d16_out_ready), .result(d16_result), .flags(d16_flags),
        .clr_sticky(d16_clr), .sticky_ovf(d16_sticky)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: evaluates the operation on plain signed integers.
    function automatic void model(input int w, input logic [3:0] op, input logic [63:0] a,
                                  input logic [63:0] b, input int sh,
                                  output logic [63:0] res, output logic [3:0] fl);
        longint mask, sa, sbv, t, maxv, minv;
        logic v, c;
        int s;
        mask = (longint'(1) << w) - longint'(1);
        maxv = (longint'(1) << (w - 1)) - longint'(1);
        minv = -(longint'(1) << (w - 1));
        sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sbv  = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        s    = sh % w;
        v    = 1'b0;
        c    = 1'b0;
        res  = 64'd0;
        case (op)
            4'd0: begin t = sa + sbv; res = t & mask; v = (t > maxv) || (t < minv); c = (t < 0); end
            4'd1: begin t = sa - sbv; res = t & mask; v = (t > maxv) || (t < minv); c = (t < 0); end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = (s == 0) ? a : (((a << s) | (a >> (w - s))) & mask);
            4'd6: res = (s == 0) ? a : (((a >> s) | (a << (w - s))) & mask);
            4'd7: res = (a << sh) & mask;
            4'd8: res = (sa >>> sh) & mask;
`ifdef ALU_SAT_EN
            4'd9, 4'd10: begin
                t = (op == 4'd9) ? sa + sbv : sa - sbv;
                if (t > maxv) begin res = maxv; v = 1'b1; end
                else if (t < minv) begin res = minv & mask; v = 1'b1; end
                else res = t & mask;
            end
`endif
            default: res = 64'd0;
        endcase
        fl = {res[w-1], (res == 64'd0), v, c};
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom % 6)
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Pops the oldest expected result and compares it with the observed output.
    task automatic sb_check(input string nm, input logic [31:0] r, input logic [3:0] f);
        exp_t e;
        if (sbq.size() == 0) begin
            check({nm, "_unexpected_output"}, 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            check({nm, "_result"}, {32'd0, r}, e.res);
            check({nm, "_flags"}, {60'd0, f}, {60'd0, e.fl});
        end
    endtask

    task automatic run16(input string nm, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] sh,
                         input logic [15:0] er, input logic [3:0] ef);
        int lat;
        @(negedge clk);
        d16_in_valid = 1'b1; d16_opcode = op; d16_op1 = a; d16_op2 = b; d16_sh = sh;
        d16_out_ready = 1'b1;
        @(posedge clk); #1;
        d16_in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!d16_out_valid && lat < 8);
        check({nm, "_latency"}, 64'(lat), 64'd2);
        check({nm, "_result"}, {48'd0, d16_result}, {48'd0, er});
        check({nm, "_flags"}, {60'd0, d16_flags}, {60'd0, ef});
        @(posedge clk);
    endtask

    initial begin
        int lat, k, n_out, cnt;
        logic [63:0] r;
        logic [3:0] f;
        logic acc, hs;

        // Directed vectors (expected values derived by hand)
        vt[0]  = '{4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 4'b1010};
        vt[1]  = '{4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 4'b0100};
        vt[2]  = '{4'h1, 32'h0000_0000, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF, 4'b1001};
        vt[3]  = '{4'h1, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 4'b0011};
        vt[4]  = '{4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 4'b1000};
        vt[5]  = '{4'h3, 32'h0000_000F, 32'h0000_00F0, 5'd0,  32'h0000_00FF, 4'b0000};
        vt[6]  = '{4'h4, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 5'd0,  32'h0000_0000, 4'b0100};
        vt[7]  = '{4'h5, 32'h8000_0001, 32'h0000_0000, 5'd1,  32'h0000_0003, 4'b0000};
        vt[8]  = '{4'h6, 32'h8000_0001, 32'h0000_0000, 5'd0,  32'h8000_0001, 4'b1000};
        vt[9]  = '{4'h6, 32'h0000_0001, 32'h0000_0000, 5'd1,  32'h8000_0000, 4'b1000};
        vt[10] = '{4'h7, 32'h0000_0001, 32'h0000_0000, 5'd31, 32'h8000_0000, 4'b1000};
        vt[11] = '{4'h8, 32'h8000_0000, 32'h0000_0000, 5'd31, 32'hFFFF_FFFF, 4'b1000};
`ifdef ALU_SAT_EN
        vt[12] = '{4'h9, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 4'b0010};
        vt[13] = '{4'hA, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h8000_0000, 4'b1010};
`else
        vt[12] = '{4'h9, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 4'b0100};
        vt[13] = '{4'hA, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h0000_0000, 4'b0100};
`endif
        vt[14] = '{4'hF, 32'h1234_5678, 32'h0000_0001, 5'd3,  32'h0000_0000, 4'b0100};

        // Reset state
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        opcode = 4'h0; op1 = 32'd0; op2 = 32'd0; sh_amount = 5'd0;
        d16_in_valid = 1'b0; d16_out_ready = 1'b0; d16_clr = 1'b0;
        d16_opcode = 4'h0; d16_op1 = 16'd0; d16_op2 = 16'd0; d16_sh = 4'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_flags", {60'd0, flags}, 64'd0);
        check("rst_sticky", {63'd0, sticky_ovf}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        sticky_exp = 1'b0;

        // Directed table, out_ready held high
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            in_valid = 1'b1; opcode = vt[i].op; op1 = vt[i].a; op2 = vt[i].b;
            sh_amount = vt[i].sh; out_ready = 1'b1;
            #1;
            check($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!out_valid && lat < 8);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
            check($sformatf("vec%0d_result", i), {32'd0, result}, {32'd0, vt[i].exp_res});
            check($sformatf("vec%0d_flags", i), {60'd0, flags}, {60'd0, vt[i].exp_fl});
            if (vt[i].exp_fl[1]) sticky_exp = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d_no_dup", i), {63'd0, out_valid}, 64'd0);
            check($sformatf("vec%0d_sticky", i), {63'd0, sticky_ovf}, {63'd0, sticky_exp});
        end

        // Back-to-back ADDs with the consumer stalled for the first 3 cycles
        k = 0; n_out = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = (c >= 3);
            in_valid  = (k < 4);
            opcode = 4'h0; op1 = 32'h0000_1000 + 32'(k); op2 = 32'(k) * 32'd3; sh_amount = 5'd0;
            #1;
            if (c == 2) begin
                check("b2b_in_ready_drop", {63'd0, in_ready}, 64'd0);
                check("b2b_accepts_before_drop", 64'(k), 64'd2);
            end
            if (out_valid && out_ready) begin
                sb_check("b2b", result, flags);
                n_out++;
            end
            if (in_valid && in_ready) begin
                model(32, opcode, {32'd0, op1}, {32'd0, op2}, int'(sh_amount), r, f);
                sbq.push_back('{r, f});
                k++;
            end
            @(posedge clk);
        end
        in_valid = 1'b0;
        check("b2b_outputs", 64'(n_out), 64'd4);

        // clr_sticky alone clears; coinciding with an overflowing handshake, set wins
        @(negedge clk);
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        @(negedge clk);
        check("clr_sticky_clears", {63'd0, sticky_ovf}, 64'd0);
        out_ready = 1'b0;
        in_valid = 1'b1; opcode = 4'h0; op1 = 32'h7FFF_FFFF; op2 = 32'h0000_0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 8);
        check("clr_vs_set_result", {32'd0, result}, 64'h8000_0000);
        check("clr_vs_set_before", {63'd0, sticky_ovf}, 64'd0);
        out_ready = 1'b1; clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        @(negedge clk);
        check("clr_vs_set_sticky", {63'd0, sticky_ovf}, 64'd1);

        // Reset while two operations are in flight
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; opcode = 4'h3; op1 = 32'h0000_0055 + 32'(i); op2 = 32'h0;
            #1;
            check($sformatf("midrst_accept%0d", i), {63'd0, in_ready}, 64'd1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        check("midrst_sticky", {63'd0, sticky_ovf}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (out_valid) cnt++;
        end
        check("midrst_no_output", 64'(cnt), 64'd0);
        sticky_exp = 1'b0;
        sbq.delete();

        // Randomized traffic with random stalls and clears
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            in_valid   = ($urandom % 4) != 0;
            out_ready  = ($urandom % 3) != 0;
            clr_sticky = ($urandom % 16) == 0;
            opcode     = 4'($urandom % 16);
            op1        = pick32();
            op2        = pick32();
            sh_amount  = 5'($urandom_range(0, 31));
            #1;
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            check("rnd_sticky", {63'd0, sticky_ovf}, {63'd0, sticky_exp});
            if (hs) begin
                if (sbq.size() != 0 && sbq[0].fl[1]) sticky_exp = 1'b1;
                else if (clr_sticky) sticky_exp = 1'b0;
                sb_check("rnd", result, flags);
            end else if (clr_sticky) begin
                sticky_exp = 1'b0;
            end
            if (acc) begin
                model(32, opcode, {32'd0, op1}, {32'd0, op2}, int'(sh_amount), r, f);
                sbq.push_back('{r, f});
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0; clr_sticky = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && sbq.size() != 0; c++) begin
            #1;
            if (out_valid) sb_check("drain", result, flags);
            @(negedge clk);
        end
        check("drain_empty", 64'(sbq.size()), 64'd0);

        // 16-bit instance vectors
        run16("w16_rol", 4'h5, 16'h8001, 16'h0000, 4'd1,  16'h0003, 4'b0000);
        run16("w16_ror0", 4'h6, 16'h8001, 16'h0000, 4'd0, 16'h8001, 4'b1000);
        run16("w16_shr", 4'h8, 16'h8000, 16'h0000, 4'd15, 16'hFFFF, 4'b1000);
        run16("w16_add_ovf", 4'h0, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 4'b1010);
        @(negedge clk);
        check("w16_sticky", {63'd0, d16_sticky}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width, legal values 8, 16, 32 or 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH): shift-amount width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: an operation is presented.
REQ-006 SHALL have port in_ready, output, 1: the block accepts the operation this cycle.
REQ-007 SHALL have port opcode, input, 4: operation select.
REQ-008 SHALL have ports op1 and op2, input, WIDTH each: signed operands.
REQ-009 SHALL have port sh_amount, input, SHW: shift or rotate count.
REQ-010 SHALL have port out_valid, output, 1: result and flags are valid.
REQ-011 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-012 SHALL have port result, output, WIDTH: signed result.
REQ-013 SHALL have port flags, output, 4: {negative, zero, overflow, carry} for the result.
REQ-014 SHALL have port clr_sticky, input, 1: clears sticky_ovf.
REQ-015 SHALL have port sticky_ovf, output, 1: accumulated overflow.

Function
REQ-016 SHALL implement opcodes 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ROL, 6 ROR, 7 SHL (logical), 8 SHR (arithmetic), 9 SADD, A SSUB; any other opcode SHALL produce result 0 with flags {0,1,0,0}.
REQ-017 SHALL use a two-stage elastic pipeline: S1 registers the accepted operands; S2 registers result and flags.
REQ-018 SHALL accept an input on in_valid && in_ready, and SHALL present the output on out_valid && out_ready.
REQ-019 SHALL deliver each result exactly 2 cycles after acceptance when out_ready is held high, and SHALL sustain one operation per cycle.
REQ-020 SHALL drive in_ready = !S1_valid || S1 advances; S1 advances when !S2_valid || out_ready.
REQ-021 SHALL hold result, flags and out_valid stable while out_valid && !out_ready; there SHALL be no loss or duplication under any stall pattern.
REQ-022 SHALL compute ADD and SUB in WIDTH+1 bits on sign-extended operands: carry = bit WIDTH of the sum (for SUB, the borrow); overflow is set when operand signs agree (ADD) or differ (SUB) and the result sign differs from op1.
REQ-023 SHALL clamp SADD and SSUB to +(2^(WIDTH-1)-1) or -2^(WIDTH-1) on overflow, with overflow flag = 1 and carry = 0.
REQ-024 SHALL return op1 unchanged for ROL and ROR when sh_amount = 0; otherwise the rotate SHALL be modulo WIDTH.
REQ-025 SHALL set carry = 0 and overflow = 0 for all logic, shift and rotate operations.
REQ-026 SHALL set zero = (result == 0) and negative = result[WIDTH-1] for every operation.
REQ-027 SHALL set sticky_ovf on each output handshake whose overflow flag = 1.
REQ-028 SHALL clear sticky_ovf on clr_sticky; when clr_sticky coincides with an overflowing handshake, set SHALL win.

Reset
REQ-029 SHALL force on rst: in_ready=0 while rst is asserted, then 1 in the first cycle after deassertion; out_valid=0; result=0; flags=0; sticky_ovf=0; S1_valid=0.
REQ-030 SHALL discard any operations in flight when rst is asserted mid-operation; no output handshake SHALL follow for them.

Configuration
REQ-031 SHALL implement SADD and SSUB per REQ-023 when ALU_SAT_EN is defined.
REQ-032 SHALL treat opcodes 9 and A as undefined per REQ-016 (result 0, flags {0,1,0,0}) when ALU_SAT_EN is not defined; the saturation logic SHALL be absent.

Verification
REQ-033 SHALL verify with WIDTH=32: ADD 0x7FFFFFFF + 1, out_ready=1 -> 2 cycles later result=0x80000000, flags {1,0,1,0}, sticky_ovf=1 the cycle after.
REQ-034 SHALL verify with ALU_SAT_EN: SADD 0x7FFFFFFF + 1 -> 0x7FFFFFFF with V=1; SSUB 0x80000000 - 1 -> 0x80000000 with V=1; without ALU_SAT_EN, opcode 9 -> 0 with Z=1.
REQ-035 SHALL verify with WIDTH=16: ROL 0x8001 by 1 -> 0x0003; ROR 0x8001 by 0 -> 0x8001; SHR 0x8000 by 15 -> 0xFFFF.
REQ-036 SHALL verify back-to-back: 4 ADDs with out_ready low for 3 cycles -> in_ready drops after 2 accepts; all 4 results emerge in order, unduplicated.
REQ-037 SHALL verify reset mid-flight: 2 ops accepted, rst pulsed -> out_valid=0 and no result appears.
REQ-038 SHALL verify clr_sticky coinciding with an overflowing handshake -> sticky_ovf remains 1.
